// File: rtl/mem_responder.sv
// Fixed-latency word memory responder for a multi-cycle CPU memory port.
// Optional MEM_RESP_CONFLICT_ERR_EN: flag and drop simultaneous read/write requests.
module mem_responder #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read_m,
    input  logic                  write_m,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WORD_WIDTH-1:0] data_in,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WRITE,
        OP_NONE
    } op_t;

    state_t                r_state;
    op_t                   r_op;
    logic [3:0]            r_count;
    logic [IDX_W-1:0]      r_index;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_data_out;
    logic                  r_ready;
    logic                  r_busy;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_commit;
    op_t                   w_accept_op;
    // Upper address bits only matter for wrap-around, which the slice below performs.
    logic [ADDR_WIDTH-1:0] w_unused_addr;

    assign w_req         = read_m | write_m;
    assign w_commit      = (r_state == BUSY) && (r_count == 4'd0);
    assign w_unused_addr = address;

`ifdef MEM_RESP_CONFLICT_ERR_EN
    logic r_err;
    logic w_conflict;

    assign w_conflict = read_m & write_m;

    always_comb begin
        w_accept_op = OP_READ;
        if (w_conflict) begin
            w_accept_op = OP_NONE;
        end else if (write_m) begin
            w_accept_op = OP_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == IDLE && w_conflict) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Simultaneous read and write resolve to a write.
    always_comb begin
        w_accept_op = OP_READ;
        if (write_m) begin
            w_accept_op = OP_WRITE;
        end
    end

    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_op       <= OP_READ;
            r_count    <= 4'd0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_index <= address[IDX_W-1:0];
                        r_wdata <= data_in;
                        r_op    <= w_accept_op;
                        r_count <= CNT_INIT;
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (r_count == 4'd0) begin
                        if (r_op == OP_READ) begin
                            r_data_out <= r_mem[r_index];
                        end
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                DONE: begin
                    // A request still held here has already been serviced.
                    if (w_req) begin
                        r_state <= HOLD;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!w_req) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is not reset; a reset on the commit edge discards the pending write.
    always_ff @(posedge clk) begin
        if (reset_n && w_commit && r_op == OP_WRITE) begin
            r_mem[r_index] <= r_wdata;
        end
    end

    assign data_out = r_data_out;
    assign ready    = r_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, hand sequences and random traffic
// checked against an array-based model of the memory.
module tb_mem_responder;

    localparam int LAT  = 2;
    localparam int LAT3 = 3;

    logic        clk;
    logic        reset_n;
    logic        read_m;
    logic        write_m;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        ready;
    logic        busy;
    logic        err;

    logic        rst3_n;
    logic        rd3;
    logic        wr3;
    logic [15:0] addr3;
    logic [15:0] din3;
    logic [15:0] dout3;
    logic        ready3;
    logic        busy3;
    logic        err3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [256];
    bit          m_valid [256];
    logic [15:0] m_dout;
    bit          m_dout_known;
    logic        m_err;

    mem_responder #(
        .WORD_WIDTH(16),
        .ADDR_WIDTH(16),
        .DEPTH     (256),
        .LATENCY   (LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .read_m  (read_m),
        .write_m (write_m),
        .address (address),
        .data_in (data_in),
        .data_out(data_out),
        .ready   (ready),
        .busy    (busy),
        .err     (err)
    );

    mem_responder #(
        .WORD_WIDTH(16),
        .ADDR_WIDTH(16),
        .DEPTH     (256),
        .LATENCY   (LAT3)
    ) dut3 (
        .clk     (clk),
        .reset_n (rst3_n),
        .read_m  (rd3),
        .write_m (wr3),
        .address (addr3),
        .data_in (din3),
        .data_out(dout3),
        .ready   (ready3),
        .busy    (busy3),
        .err     (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int hold, input bit scramble);
        int k;
        int idx;
        k = 0;
        read_m  = rd;
        write_m = wr;
        address = a;
        data_in = d;
        for (int i = 1; i <= LAT + 4 && k == 0; i++) begin
            @(posedge clk);
            #1;
            if (scramble && i == 1) begin
                address = 16'h0010;
                data_in = ~d;
            end
            @(negedge clk);
            if (ready) k = i;
            else chk("busy_while_pending", {31'd0, busy}, 32'd1);
        end
        chk("ready_latency", k, LAT + 1);

        idx = int'(a) % 256;
        if (rd && wr) begin
`ifdef MEM_RESP_CONFLICT_ERR_EN
            m_err = 1'b1;
`else
            m_mem[idx]   = d;
            m_valid[idx] = 1'b1;
`endif
        end else if (wr) begin
            m_mem[idx]   = d;
            m_valid[idx] = 1'b1;
        end else if (m_valid[idx]) begin
            m_dout       = m_mem[idx];
            m_dout_known = 1'b1;
        end else begin
            m_dout_known = 1'b0;
        end
        if (m_dout_known) chk("data_out", {16'd0, data_out}, {16'd0, m_dout});
        chk("err", {31'd0, err}, {31'd0, m_err});

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_no_ready", {31'd0, ready}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        read_m  = 1'b0;
        write_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_dropped", {31'd0, ready}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic xact3(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, output int k);
        k     = 0;
        rd3   = rd;
        wr3   = wr;
        addr3 = a;
        din3  = d;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready3) k = i;
        end
        rd3 = 1'b0;
        wr3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] a;
        logic [15:0] d;
        bit          scr;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        int pulses;

        vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0103, 16'hBEEF, 1'b0, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
`ifdef MEM_RESP_CONFLICT_ERR_EN
        vecs[4] = '{1'b1, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 16'hBEEF, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b1};
`else
        vecs[4] = '{1'b1, 1'b1, 16'h0005, 16'hAAAA, 1'b0, 16'hBEEF, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hAAAA, 1'b0};
`endif

        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;

        // Reset held with a pending read request
        reset_n = 1'b0;
        read_m  = 1'b1;
        write_m = 1'b0;
        address = 16'h0040;
        data_in = 16'h0000;
        rst3_n  = 1'b0;
        rd3     = 1'b0;
        wr3     = 1'b0;
        addr3   = 16'h0000;
        din3    = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data_out", {16'd0, data_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        rst3_n  = 1'b1;
        m_err   = 1'b0;
        xact(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 1'b0);

        // Re-reset to a clean data_out before the vector table
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n      = 1'b1;
        m_dout       = 16'h0000;
        m_dout_known = 1'b1;
        m_err        = 1'b0;

        for (int i = 0; i < 6; i++) begin
            xact(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 0, vecs[i].scr);
            chk("vec_data_out", {16'd0, data_out}, {16'd0, vecs[i].exp_dout});
            chk("vec_err", {31'd0, err}, {31'd0, vecs[i].exp_err});
        end

        // Held read: one pulse only, busy until the request drops
        xact(1'b1, 1'b0, 16'h0005, 16'h0000, 10, 1'b0);

        // Random traffic over a small index set with random upper address bits
        for (int n = 0; n < 60; n++) begin
            int          sel;
            logic [15:0] a;
            sel = int'($urandom_range(0, 9));
            a   = {8'($urandom), 8'($urandom_range(0, 15))};
            if (sel <= 3)      xact(1'b0, 1'b1, a, 16'($urandom), int'($urandom_range(0, 2)),
                                    1'($urandom_range(0, 1)));
            else if (sel <= 8) xact(1'b1, 1'b0, a, 16'h0000, int'($urandom_range(0, 2)),
                                    1'($urandom_range(0, 1)));
            else               xact(1'b1, 1'b1, a, 16'($urandom), int'($urandom_range(0, 2)),
                                    1'($urandom_range(0, 1)));
        end

        // LATENCY=3 instance: reset one edge after acceptance of a write
        xact3(1'b0, 1'b1, 16'h0020, 16'h1111, k);
        chk("lat3_write_latency", k, LAT3 + 1);
        wr3   = 1'b1;
        addr3 = 16'h0020;
        din3  = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        chk("lat3_busy_after_accept", {31'd0, busy3}, 32'd1);
        rst3_n = 1'b0;
        wr3    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready3) pulses++;
        end
        chk("lat3_no_ready_after_abort", pulses, 0);
        chk("lat3_idle_after_abort", {31'd0, busy3}, 32'd0);
        xact3(1'b1, 1'b0, 16'h0020, 16'h0000, k);
        chk("lat3_read_latency", k, LAT3 + 1);
        chk("lat3_write_discarded", {16'd0, dout3}, 32'h0000_1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
